// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / restoring divide feeding the HI/LO registers.
// Operands are processed as magnitudes and the signs are reapplied in the FIX cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             RESET_in,
    input  logic             MultOp,
    input  logic             DivOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DZERO,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               sign_q;
    logic               sign_r;
    logic               is_div;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_step;
    logic               start_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The most negative value maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign a_mag     = A[WIDTH-1] ? (-A) : A;
    assign b_mag     = B[WIDTH-1] ? (-B) : B;
    assign last_step = (count == CNT_W'(WIDTH - 1));
    assign start_op  = MultOp || (DivOp && (B != '0));

    // Multiply: rem accumulates the upper half while quo shifts the multiplier out and product bits in.
    assign mul_sum   = {1'b0, rem} + (quo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});

    // Divide: quo shifts the dividend into rem and collects quotient bits from the bottom.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_b};

    assign product   = {rem, quo};
    assign prod_fix  = sign_q ? (-product) : product;
    assign quo_fix   = sign_q ? (-quo) : quo;
    assign rem_fix   = sign_r ? (-rem) : rem;

    always_ff @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        DivZero    = 1'b0;
        case (state)
            IDLE: begin
                if (MultOp) begin
                    state_next = MULT;
                end else if (DivOp) begin
                    state_next = (B == '0) ? DZERO : DIV;
                end
            end
            MULT: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = FIX;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            DZERO: begin
                DivZero    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) begin
            count  <= '0;
            op_b   <= '0;
            rem    <= '0;
            quo    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            is_div <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_op) begin
                        count  <= '0;
                        rem    <= '0;
                        quo    <= a_mag;
                        op_b   <= b_mag;
                        sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r <= A[WIDTH-1];
                        is_div <= !MultOp;
                    end
                end
                MULT: begin
                    rem   <= mul_sum[WIDTH:1];
                    quo   <= {mul_sum[0], quo[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                end
                DIV: begin
                    if (!div_diff[WIDTH]) begin
                        rem <= div_diff[WIDTH-1:0];
                    end else begin
                        rem <= div_shift[WIDTH-1:0];
                    end
                    quo   <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    if (is_div) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: a cycle-count reference model checked every cycle,
// directed cases with literal results, then a long randomized stretch.
module tb_muldiv_sequencer;

    logic        clock;
    logic        RESET_in;
    logic        MultOp;
    logic        DivOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        DivZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int pass_count  = 0;
    int check_count = 0;
    bit check_en    = 0;

    // Reference model: cycles since start (0 = idle), pending result and visible HI/LO.
    int          m_t  = 0;
    bit          m_dz = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_pend_hi = '0;
    logic [31:0] m_pend_lo = '0;

    muldiv_sequencer dut (
        .clock    (clock),
        .RESET_in (RESET_in),
        .MultOp   (MultOp),
        .DivOp    (DivOp),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .DivZero  (DivZero),
        .HI       (HI),
        .LO       (LO)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}; 64-bit math makes the MIN/-1 wrap fall out naturally.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    always @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) begin
            m_t  = 0;
            m_dz = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_dz) begin
            m_dz = 0;
        end else if (m_t != 0) begin
            m_t++;
            if (m_t == 34) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end else if (m_t == 35) begin
                m_t = 0;
            end
        end else if (MultOp) begin
            {m_pend_hi, m_pend_lo} = ref_mul(A, B);
            m_t = 1;
        end else if (DivOp) begin
            if (B == 32'd0) begin
                m_dz = 1;
            end else begin
                {m_pend_hi, m_pend_lo} = ref_div(A, B);
                m_t = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("busy",    64'(busy),    64'(m_t >= 1 && m_t <= 33));
            checkOutput("done",    64'(done),    64'(m_t == 34));
            checkOutput("DivZero", 64'(DivZero), 64'(m_dz));
            checkOutput("HI",      64'(HI),      64'(m_hi));
            checkOutput("LO",      64'(LO),      64'(m_lo));
        end
    end

    // Called on a falling edge; start is sampled on the next rising edge, then operands are scrambled.
    task automatic applyStimulus(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
        MultOp = mult;
        DivOp  = div;
        A      = a;
        B      = b;
        @(negedge clock);
        MultOp = 1'b0;
        DivOp  = 1'b0;
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic waitDone(input string name, input int exp_busy);
        int busy_cycles = 0;
        int cycles      = 0;
        while (!done && cycles < 100) begin
            if (busy) begin
                busy_cycles++;
            end
            @(negedge clock);
            cycles++;
        end
        checkOutput({name, " done"}, 64'(done), 64'd1);
        checkOutput({name, " busy cycles"}, 64'(busy_cycles), 64'(exp_busy));
    endtask

    initial begin
        int extra_done;
        RESET_in = 1'b1;
        MultOp   = 1'b0;
        DivOp    = 1'b0;
        A        = '0;
        B        = '0;
        #1 RESET_in = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy",    64'(busy),    64'd0);
        checkOutput("reset done",    64'(done),    64'd0);
        checkOutput("reset DivZero", 64'(DivZero), 64'd0);
        checkOutput("reset HI",      64'(HI),      64'd0);
        checkOutput("reset LO",      64'(LO),      64'd0);
        check_en = 1;
        RESET_in = 1'b1;
        @(negedge clock);

        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        waitDone("mul 7*-3", 33);
        checkOutput("mul 7*-3 HI", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        checkOutput("mul 7*-3 LO", 64'(LO), 64'h0000_0000_FFFF_FFEB);
        @(negedge clock);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone("div -7/2", 33);
        checkOutput("div -7/2 LO", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        checkOutput("div -7/2 HI", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        @(negedge clock);

        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
        waitDone("div 100/7", 33);
        checkOutput("div 100/7 LO", 64'(LO), 64'd14);
        checkOutput("div 100/7 HI", 64'(HI), 64'd2);
        @(negedge clock);

        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
        checkOutput("dz pulse", 64'(DivZero), 64'd1);
        checkOutput("dz busy",  64'(busy),    64'd0);
        @(negedge clock);
        checkOutput("dz pulse ends", 64'(DivZero), 64'd0);
        repeat (3) @(negedge clock);
        checkOutput("dz HI kept", 64'(HI), 64'd2);
        checkOutput("dz LO kept", 64'(LO), 64'd14);

        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        waitDone("both min*min", 33);
        checkOutput("min*min HI", 64'(HI), 64'h0000_0000_4000_0000);
        checkOutput("min*min LO", 64'(LO), 64'd0);
        @(negedge clock);

        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div min/-1", 33);
        checkOutput("min/-1 LO", 64'(LO), 64'h0000_0000_8000_0000);
        checkOutput("min/-1 HI", 64'(HI), 64'd0);
        @(negedge clock);

        applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (9) @(negedge clock);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd9);
        waitDone("mul 5*6 with ignored start", 23);
        checkOutput("mul 5*6 HI", 64'(HI), 64'd0);
        checkOutput("mul 5*6 LO", 64'(LO), 64'd30);
        extra_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) begin
                extra_done++;
            end
        end
        checkOutput("no second done", 64'(extra_done), 64'd0);

        applyStimulus(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (13) @(negedge clock);
        @(posedge clock);
        #2 RESET_in = 1'b0;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset done", 64'(done), 64'd0);
        checkOutput("async reset HI",   64'(HI),   64'd0);
        checkOutput("async reset LO",   64'(LO),   64'd0);
        @(negedge clock);
        @(negedge clock);
        RESET_in = 1'b1;
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
        waitDone("mul 3*4 after reset", 33);
        checkOutput("mul 3*4 HI", 64'(HI), 64'd0);
        checkOutput("mul 3*4 LO", 64'(LO), 64'd12);
        @(negedge clock);

        for (int i = 0; i < 6000; i++) begin
            MultOp = ($urandom_range(0, 15) == 0);
            DivOp  = ($urandom_range(0, 9) == 0);
            A      = pick_operand();
            B      = pick_operand();
            @(negedge clock);
        end
        MultOp = 1'b0;
        DivOp  = 1'b0;
        repeat (40) @(negedge clock);

        check_en = 0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the multicycle MIPS core.
- Accepts one-cycle MultOp/DivOp start pulses from Unidade_Controle and runs a shared iterative datapath: radix-2 shift-add multiply or restoring divide, 32 iterations, with sign pre/post-processing.
- Drives busy/done back to the control unit (Mult_s/Div_s wait, then WriteHILO_s) and flags divide-by-zero for the exception path (PCtoEPC_s).

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- RESET_in  input  1  asynchronous, active-low reset.
- MultOp  input  1  start signed multiply; sampled only in IDLE.
- DivOp  input  1  start signed divide; sampled only in IDLE.
- A  input  WIDTH  rs operand (multiplicand / dividend); captured on the start cycle.
- B  input  WIDTH  rt operand (multiplier / divisor); captured on the start cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- DivZero  output  1  one-cycle pulse; a divide was started with B == 0.
- HI  output  WIDTH  registered upper product / remainder.
- LO  output  WIDTH  registered lower product / quotient.

Behaviour:
- Reset (RESET_in low, asynchronous): state = IDLE, counter = 0, busy = 0, done = 0, DivZero = 0, HI = 0, LO = 0, internal operand registers = 0.
- Reset mid-operation aborts the operation and HI/LO clear. Leaving reset produces no done pulse.
- States: IDLE, MULT, DIV, DZERO, FIX, DONE.
- Cycle S is the cycle in which a start signal is sampled high in IDLE.
- IDLE:
  - MultOp = 1: capture |A| and |B| plus the result sign (A[31]^B[31]); go to MULT.
  - DivOp = 1 and B == 0: go to DZERO.
  - DivOp = 1 and B != 0: capture |A|, |B|, quotient sign (A[31]^B[31]) and remainder sign (A[31]); go to DIV.
  - MultOp and DivOp both high: multiply wins and DivOp is dropped.
- MULT: one shift-add step per cycle; counter counts 0..WIDTH-1. After step WIDTH-1, go to FIX.
- DIV: one restoring step per cycle: shift remainder, trial-subtract, set quotient bit. After WIDTH steps, go to FIX.
- FIX (one cycle):
  - Negate the magnitude result(s) if the corresponding sign is set. Multiply negates the full 2*WIDTH product; divide negates the quotient and remainder independently.
  - Register the results into HI/LO; go to DONE.
- DONE: done = 1 for one cycle; return to IDLE. A new start is accepted in the cycle after DONE, never in DONE itself.
- DZERO: DivZero = 1 for one cycle, busy = 0; HI/LO unchanged; return to IDLE. No done pulse.
- Latency:
  - Multiply and divide: busy = 1 in cycles S+1..S+33, done in S+34. Both use 32 iterations + FIX.
  - Divide by zero: DivZero in S+1.
- Start pulses while busy or in DONE/DZERO are ignored; no queueing.
- HI/LO change only on the FIX→DONE edge or on reset. Operand changes after S have no effect.
- Arithmetic:
  - Multiply: {HI,LO} = signed 64-bit A*B.
  - Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no flag).
  - |0x80000000| = 0x80000000 is treated as unsigned 2^31 internally, so a 33-bit magnitude path is not needed.

Test Plan:
- MultOp pulse, A = 7, B = 0xFFFFFFFD (−3) → busy S+1..S+33; done at S+34 with HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DivOp pulse, A = 0xFFFFFFF9 (−7), B = 2 → done at S+34 with LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; then A = 100, B = 7 → LO = 14, HI = 2.
- HI/LO preloaded to 14/2, then DivOp with A = 5, B = 0 → DivZero = 1 only in S+1; busy never rises; no done; HI/LO stay 14/2.
- MultOp and DivOp same cycle, A = B = 0x80000000 → multiply performed: HI = 0x40000000, LO = 0; then DivOp with A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Second MultOp at S+10 with different operands → ignored; the first result delivered at S+34 and no second done.
- RESET_in low at S+15 → busy, done, HI, LO = 0 immediately (asynchronous). After release, a new MultOp with A = 3, B = 4 completes normally: HI = 0, LO = 12.
